// File: rtl/div_seq.sv
// rtl/div_seq.sv - radix-2 restoring sequential divider for DIV/DIVU
// Produces {remainder, quotient} one quotient bit per cycle, sign-corrected at completion.

module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH+1:0] trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             last_iter;

  always_comb begin
    a_neg = signed_div_i & opdata1_i[WIDTH-1];
    b_neg = signed_div_i & opdata2_i[WIDTH-1];
    mag1  = a_neg ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    mag2  = b_neg ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

    // quo holds the not-yet-consumed dividend bits; its MSB shifts into the remainder
    trial  = {1'b0, rem, quo[WIDTH-1]} - {2'b00, dvs};
    qbit   = ~trial[WIDTH+1];
    rem_nx = qbit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], quo[WIDTH-1]};
    quo_nx = {quo[WIDTH-2:0], qbit};

    q_fix     = neg_q ? (~quo_nx + WIDTH'(1)) : quo_nx;
    r_fix     = neg_r ? (~rem_nx + WIDTH'(1)) : rem_nx;
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !annul_i) begin
            busy_o <= 1'b1;
            if (opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              quo   <= mag1;
              rem   <= '0;
              dvs   <= mag2;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              cnt   <= '0;
              state <= RUN;
            end
          end
        end

        BYZERO: begin
          busy_o <= 1'b0;
          if (annul_i) begin
            state <= IDLE;
          end else begin
            state    <= DONE;
            result_o <= '0;
            ready_o  <= 1'b1;
          end
        end

        RUN: begin
          // annul wins over completion, leaving result_o untouched
          if (annul_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            quo <= quo_nx;
            rem <= rem_nx;
            cnt <= cnt + CW'(1);
            if (last_iter) begin
              state    <= DONE;
              busy_o   <= 1'b0;
              ready_o  <= 1'b1;
              result_o <= {r_fix, q_fix};
            end
          end
        end

        DONE: begin
          if (annul_i || !start_i) begin
            state   <= IDLE;
            ready_o <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          ready_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq against an arithmetic reference
// Directed test-plan scenarios plus randomized signed/unsigned divisions.

module tb_div_seq;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic           annul_i;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  // Reference: language division on 64-bit integers; % truncates, so remainder follows dividend sign
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!ready_o && n < 100);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    step(); step();
    rst = 1'b0;
    n_checks++; if (result_o !== 64'd0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result_o); end
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_unsigned();
    int n;
    logic [63:0] exp;
    exp = {32'h0000_0002, 32'h0000_000E};
    start_div(1'b0, 32'd100, 32'd7);
    step();
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL divu_busy got=%b exp=1", busy_o); end
    n = 1;
    while (!ready_o && n < 100) begin step(); n++; end
    n_checks++; if (ready_o !== 1'b1 || n != 33) begin n_fail++; $display("FAIL divu_latency ready=%b edges=%0d exp=33", ready_o, n); end
    n_checks++; if (result_o !== exp) begin n_fail++; $display("FAIL divu_result got=%h exp=%h", result_o, exp); end
    step();
    n_checks++; if (ready_o !== 1'b1 || result_o !== exp) begin n_fail++; $display("FAIL divu_hold ready=%b got=%h exp=%h", ready_o, result_o, exp); end
    start_i = 1'b0;
    step();
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL divu_drop ready=%b exp=0", ready_o); end
    n_checks++; if (result_o !== exp) begin n_fail++; $display("FAIL divu_keep got=%h exp=%h", result_o, exp); end
  endtask

  task automatic test_signed();
    int n;
    logic [31:0] a_tab [2];
    logic [31:0] b_tab [2];
    logic [63:0] e_tab [2];
    a_tab[0] = 32'hFFFF_FFF9; b_tab[0] = 32'd2;          e_tab[0] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    a_tab[1] = 32'd7;         b_tab[1] = 32'hFFFF_FFFE;  e_tab[1] = {32'h0000_0001, 32'hFFFF_FFFD};
    for (int i = 0; i < 2; i++) begin
      start_div(1'b1, a_tab[i], b_tab[i]);
      wait_ready(n);
      n_checks++; if (ready_o !== 1'b1 || n != 33) begin n_fail++; $display("FAIL div_latency case=%0d ready=%b edges=%0d exp=33", i, ready_o, n); end
      n_checks++; if (result_o !== e_tab[i]) begin n_fail++; $display("FAIL div_result case=%0d got=%h exp=%h", i, result_o, e_tab[i]); end
      start_i = 1'b0;
      step();
    end
  endtask

  task automatic test_byzero();
    start_div(1'b0, 32'h1234_5678, 32'd0);
    step();
    n_checks++; if (busy_o !== 1'b1 || ready_o !== 1'b0) begin n_fail++; $display("FAIL byzero_edge1 busy=%b ready=%b exp busy=1 ready=0", busy_o, ready_o); end
    step();
    n_checks++; if (busy_o !== 1'b0 || ready_o !== 1'b1) begin n_fail++; $display("FAIL byzero_edge2 busy=%b ready=%b exp busy=0 ready=1", busy_o, ready_o); end
    n_checks++; if (result_o !== 64'd0) begin n_fail++; $display("FAIL byzero_result got=%h exp=0", result_o); end
    start_i = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    int n;
    logic [63:0] exp;
    exp = {32'h0000_0000, 32'h8000_0000};
    start_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready(n);
    n_checks++; if (ready_o !== 1'b1 || result_o !== exp) begin n_fail++; $display("FAIL overflow ready=%b got=%h exp=%h", ready_o, result_o, exp); end
    start_i = 1'b0;
    step();
  endtask

  task automatic test_annul();
    int n;
    bit seen;
    logic [63:0] prev;
    start_div(1'b0, 32'd1000, 32'd13);
    step();
    repeat (9) step();
    annul_i = 1'b1;
    prev = result_o;
    step();
    annul_i = 1'b0;
    n_checks++; if (busy_o !== 1'b0 || ready_o !== 1'b0) begin n_fail++; $display("FAIL annul_mid busy=%b ready=%b exp 0 0", busy_o, ready_o); end
    n_checks++; if (result_o !== prev) begin n_fail++; $display("FAIL annul_keep got=%h exp=%h", result_o, prev); end
    start_div(1'b0, 32'd9, 32'd3);
    wait_ready(n);
    n_checks++; if (ready_o !== 1'b1 || n != 33) begin n_fail++; $display("FAIL annul_restart_lat ready=%b edges=%0d exp=33", ready_o, n); end
    n_checks++; if (result_o !== {32'd0, 32'd3}) begin n_fail++; $display("FAIL annul_restart got=%h exp=%h", result_o, {32'd0, 32'd3}); end
    start_i = 1'b0;
    step();

    start_div(1'b0, 32'd1000, 32'd13);
    step();
    repeat (31) step();
    n_checks++; if (ready_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL annul_pre_last ready=%b busy=%b exp 0 1", ready_o, busy_o); end
    annul_i = 1'b1;
    start_i = 1'b0;
    prev = result_o;
    step();
    annul_i = 1'b0;
    seen = ready_o;
    repeat (40) begin step(); seen |= ready_o; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL annul_last ready_seen=%b exp=0", seen); end
    n_checks++; if (result_o !== prev || busy_o !== 1'b0) begin n_fail++; $display("FAIL annul_last_state got=%h busy=%b exp=%h 0", result_o, busy_o, prev); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    logic [63:0] exp;
    exp = {32'h0000_000F, 32'h0FFF_FFFF};
    start_div(1'b0, 32'hDEAD_BEEF, 32'd3);
    step();
    repeat (19) step();
    rst = 1'b1;
    start_i = 1'b0;
    step();
    rst = 1'b0;
    n_checks++; if (result_o !== 64'd0 || ready_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid got=%h ready=%b busy=%b exp all 0", result_o, ready_o, busy_o); end
    start_div(1'b0, 32'hFFFF_FFFF, 32'h10);
    wait_ready(n);
    n_checks++; if (ready_o !== 1'b1 || n != 33) begin n_fail++; $display("FAIL rst_after_lat ready=%b edges=%0d exp=33", ready_o, n); end
    n_checks++; if (result_o !== exp) begin n_fail++; $display("FAIL rst_after got=%h exp=%h", result_o, exp); end
    start_i = 1'b0;
    step();
  endtask

  task automatic test_operand_latch();
    int n;
    logic [31:0] a, b;
    logic [63:0] exp;
    a = 32'hFFFF_0000 | 32'($urandom_range(0, 65535));
    b = 32'($urandom_range(3, 999));
    exp = ref_div(1'b1, a, b);
    start_div(1'b1, a, b);
    step();
    signed_div_i = 1'b0;
    opdata1_i = $urandom;
    opdata2_i = 32'd0;
    wait_ready(n);
    n_checks++; if (ready_o !== 1'b1 || result_o !== exp) begin n_fail++; $display("FAIL latch ready=%b got=%h exp=%h", ready_o, result_o, exp); end
    start_i = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] a, b;
    for (int i = 0; i < 2; i++) begin
      a = $urandom;
      b = 32'($urandom_range(1, 1 << 20));
      start_div(1'b0, a, b);
      wait_ready(n);
      n_checks++; if (ready_o !== 1'b1 || n != 33 || result_o !== ref_div(1'b0, a, b)) begin n_fail++; $display("FAIL b2b_%0d ready=%b edges=%0d got=%h exp=%h", i, ready_o, n, result_o, ref_div(1'b0, a, b)); end
      start_i = 1'b0;
      step();
    end
  endtask

  task automatic test_random();
    int n, exp_lat;
    logic s;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      exp = ref_div(s, a, b);
      exp_lat = (b == 32'd0) ? 2 : 33;
      start_div(s, a, b);
      wait_ready(n);
      n_checks++; if (ready_o !== 1'b1 || n != exp_lat) begin n_fail++; $display("FAIL rand_lat_%0d ready=%b edges=%0d exp=%0d", i, ready_o, n, exp_lat); end
      n_checks++; if (result_o !== exp) begin n_fail++; $display("FAIL rand_res_%0d s=%b a=%h b=%h got=%h exp=%h", i, s, a, b, result_o, exp); end
      start_i = 1'b0;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_byzero();
    test_overflow();
    test_annul();
    test_reset_mid_run();
    test_operand_latch();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
